bitmap_index_iter: RTL and testbench
====================================

// Module: bitmap_index_iter
// PURPOSE
//  - Sequential counterpart of the combinational encoder: accepts a WIDTH-bit mask and emits the index
//    of every set bit, one per accepted output beat, LSB first.
//  - Sits between a bitmap producer (match/valid vectors) and a per-entry consumer needing a stream of indices.
//  - Valid/ready handshake on both sides; supports back-to-back masks without bubbles.
// PARAMETERS
//  - WIDTH  16            mask width, >= 2
//  - IW     `CLOG2(WIDTH) index width, derived, not overridden
// PORTS
//  - clk         in   1      single clock, all state updates on rising edge
//  - rst         in   1      reset, synchronous, active-high
//  - flush       in   1      synchronous abort of the mask in progress
//  - in_vld      in   1      input mask valid
//  - in_rdy      out  1      block can take a new mask
//  - in_mask     in   WIDTH  mask to iterate
//  - out_vld     out  1      out_idx valid
//  - out_rdy     in   1      consumer accepts out_idx
//  - out_idx     out  IW     index of lowest set bit still pending
//  - out_last    out  1      out_idx is the final index of the current mask
//  - out_onehot  out  WIDTH  present only with BITMAP_ITER_ONEHOT_EN
// BEHAVIOUR
//  - State: ST_IDLE / ST_BUSY, plus a WIDTH-bit residual register `res`.
//  - Reset: state=ST_IDLE, res=0. Outputs: out_vld=0, out_idx=0, out_last=0, in_rdy=1 in the first cycle after rst.
//  - in_rdy = ~flush & (state==ST_IDLE | (out_vld & out_last & out_rdy)). This is combinational on out_rdy.
//  - Accept (in_vld & in_rdy):
//    - mask!=0: res<=in_mask, state<=ST_BUSY. First out_vld appears in the next cycle (latency 1).
//    - mask==0: mask is consumed and dropped. No output beat. State stays or becomes ST_IDLE.
//  - ST_BUSY:
//    - out_vld=1.
//    - out_idx = position of lowest set bit of res.
//    - out_last = res has exactly one bit set.
//  - Output transfer (out_vld & out_rdy): clear that bit in res.
//    - If out_last and no simultaneous accept: state<=ST_IDLE.
//    - If out_last with a simultaneous accept: the new mask loads, and there is no bubble.
//  - Backpressure: while out_rdy=0, out_vld, out_idx and out_last hold stable. res changes only on a transfer.
//  - Outputs depend only on the registered res/state, never on in_* (no in-to-out combinational path).
//  - flush=1:
//    - Next cycle: state=ST_IDLE, res=0.
//    - An output transfer in the same cycle still completes.
//    - An input handshake is blocked (in_rdy=0).
//  - rst or flush mid-mask discards all remaining indices. Nothing is replayed.
//  - Index arithmetic: IW bits, range 0..WIDTH-1. No wrap. Order is strictly ascending within a mask.
// CONFIGURATION
//  - Macro BITMAP_ITER_ONEHOT_EN:
//    - Defined: adds port out_onehot = 1<<out_idx when out_vld, else 0. It is driven as res & ~(res-1).
//    - Not defined: the port and its logic are absent. The index stream is unchanged.
// STRUCTURE
//  - lib.vh provides `CLOG2 and the state localparams ST_IDLE=1'b0, ST_BUSY=1'b1. The state encodings are shared
//    with other handshake blocks.
//  - Sub-module bitmap_lsb_enc #(WIDTH): combinational lowest-set-bit priority encoder.
//    - Outputs: idx[IW-1:0], any, single.
//    - Instanced once on res.
//  - Top holds the state register, res, handshake logic and the optional one-hot output.
// TESTING (WIDTH=16)
//  - Reset: hold rst 2 cycles with in_vld=1 -> out_vld=0, in_rdy=1 after release. No mask is captured while rst=1.
//  - Burst: mask 16'h8421 accepted at cycle N, out_rdy=1:
//    - idx 0,5,10,15 on cycles N+1..N+4.
//    - out_last=1 only with 15.
//    - With macro: out_onehot 16'h0001, 16'h0020, 16'h0400, 16'h8000.
//  - Backpressure: mask 16'h0003, out_rdy=0 for 3 cycles -> idx 0 held with out_vld=1, then 0,1. in_rdy=0 until the last beat.
//  - Back-to-back: masks 16'h0001 then 16'h8000, in_vld held -> idx 0 (last) then 15 (last) on consecutive cycles, no bubble.
//  - Zero mask: 16'h0000 accepted -> out_vld stays 0, in_rdy stays 1. A following 16'h0004 yields idx 2.
//  - Flush: mask 16'hFFFF, flush asserted after idx 0,1,2 transfer -> out_vld=0 next cycle, in_rdy=1. The next mask starts fresh.

Source files
------------

// File: rtl/bitmap_index_iter_pkg.sv
// Shared types and helpers for the bitmap index iterator: handshake state encoding and index-width math.
package bitmap_index_iter_pkg;

    // State encoding is shared with the other handshake blocks; keep values fixed.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bitmap_lsb_enc.sv
// Combinational lowest-set-bit priority encoder: index of the lowest set bit, plus any/single flags.
module bitmap_lsb_enc
    import bitmap_index_iter_pkg::*;
#(
    parameter  int WIDTH = 16,
    localparam int IW    = clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IW-1:0]    idx,
    output logic             any,
    output logic             single
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    // Scan downward so the lowest set bit is the final assignment.
    always_comb begin
        idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IW'(i);
            end
        end
    end

    assign any    = |vec;
    assign single = any && ((vec & (vec - ONE)) == '0);

endmodule

// File: rtl/bitmap_index_iter.sv
// Streams the index of every set bit of an accepted mask, LSB first, with valid/ready on both sides.
// Optional out_onehot port is enabled by defining BITMAP_ITER_ONEHOT_EN.
module bitmap_index_iter
    import bitmap_index_iter_pkg::*;
#(
    parameter  int WIDTH = 16,
    localparam int IW    = clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [WIDTH-1:0] in_mask,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [IW-1:0]    out_idx,
    output logic             out_last
`ifdef BITMAP_ITER_ONEHOT_EN
    ,
    output logic [WIDTH-1:0] out_onehot
`endif
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] low_bit;
    logic [IW-1:0]    enc_idx;
    logic             enc_any;
    logic             enc_single;
    logic             xfer;
    logic             accept;

    bitmap_lsb_enc #(
        .WIDTH (WIDTH)
    ) u_enc (
        .vec    (res_q),
        .idx    (enc_idx),
        .any    (enc_any),
        .single (enc_single)
    );

    assign low_bit = res_q & ~(res_q - ONE);
    assign xfer    = out_vld & out_rdy;
    assign accept  = in_vld & in_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
        end
    end

    // Accept is only possible when res is empty or its last bit leaves this cycle,
    // so loading the new mask never drops a pending index.
    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        if (xfer) begin
            res_d = res_q & ~low_bit;
            if (out_last) begin
                state_d = ST_IDLE;
            end
        end
        if (accept) begin
            if (in_mask != '0) begin
                res_d   = in_mask;
                state_d = ST_BUSY;
            end else begin
                res_d   = '0;
                state_d = ST_IDLE;
            end
        end
        if (flush) begin
            res_d   = '0;
            state_d = ST_IDLE;
        end
    end

    always_comb begin
        out_vld  = (state_q == ST_BUSY) && enc_any;
        out_idx  = enc_idx;
        out_last = out_vld && enc_single;
        in_rdy   = ~flush & ((state_q == ST_IDLE) | (out_vld & out_last & out_rdy));
    end

`ifdef BITMAP_ITER_ONEHOT_EN
    assign out_onehot = out_vld ? low_bit : '0;
`endif

endmodule

// File: tb/tb_bitmap_index_iter.sv
// Self-checking bench for bitmap_index_iter: directed scenarios plus random traffic against a queue model.
module tb_bitmap_index_iter;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_vld;
    logic        in_rdy;
    logic [15:0] in_mask;
    logic        out_vld;
    logic        out_rdy;
    logic [3:0]  out_idx;
    logic        out_last;
`ifdef BITMAP_ITER_ONEHOT_EN
    logic [15:0] out_onehot;
`endif

    int compared;
    int mismatched;
    int model_q[$];
    int obs_q[$];
    int obs_last_q[$];

    bitmap_index_iter #(
        .WIDTH (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_vld   (in_vld),
        .in_rdy   (in_rdy),
        .in_mask  (in_mask),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .out_idx  (out_idx),
        .out_last (out_last)
`ifdef BITMAP_ITER_ONEHOT_EN
        ,
        .out_onehot (out_onehot)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // One cycle: drive inputs after the falling edge, check outputs against the model,
    // then advance the model over the rising edge.
    task automatic step(input logic r, input logic f, input logic iv,
                        input logic [15:0] m, input logic ordy);
        logic exp_vld, exp_last, exp_rdy, acc;
        int   exp_idx;
        rst = r; flush = f; in_vld = iv; in_mask = m; out_rdy = ordy;
        #1;
        exp_vld  = (model_q.size() != 0);
        exp_idx  = exp_vld ? model_q[0] : 0;
        exp_last = (model_q.size() == 1);
        exp_rdy  = !f && (model_q.size() == 0 || (model_q.size() == 1 && ordy));
        if (!r) begin
            check("out_vld", 32'(out_vld), 32'(exp_vld));
            check("in_rdy", 32'(in_rdy), 32'(exp_rdy));
            if (exp_vld) begin
                check("out_idx", 32'(out_idx), 32'(exp_idx));
                check("out_last", 32'(out_last), 32'(exp_last));
            end
`ifdef BITMAP_ITER_ONEHOT_EN
            check("out_onehot", 32'(out_onehot), exp_vld ? (32'd1 << exp_idx) : 32'd0);
`endif
            if (out_vld && ordy) begin
                obs_q.push_back(int'(out_idx));
                obs_last_q.push_back(int'(out_last));
            end
        end
        acc = iv && exp_rdy;
        @(posedge clk);
        if (r) begin
            model_q.delete();
        end else begin
            if (exp_vld && ordy) void'(model_q.pop_front());
            if (acc) begin
                model_q.delete();
                for (int i = 0; i < 16; i++) if (m[i]) model_q.push_back(i);
            end
            if (f) model_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic idle_cycles(input int n, input logic ordy);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 16'h0000, ordy);
    endtask

    task automatic check_obs(input string tag, input int exp_idx[$], input int exp_last[$]);
        check({tag, "_count"}, 32'(obs_q.size()), 32'(exp_idx.size()));
        for (int i = 0; i < exp_idx.size() && i < obs_q.size(); i++) begin
            check({tag, "_idx"}, 32'(obs_q[i]), 32'(exp_idx[i]));
            check({tag, "_last"}, 32'(obs_last_q[i]), 32'(exp_last[i]));
        end
        obs_q.delete();
        obs_last_q.delete();
    endtask

    initial begin
        logic [15:0] rm;
        compared = 0;
        mismatched = 0;
        rst = 1'b1; flush = 1'b0; in_vld = 1'b1; in_mask = 16'hFFFF; out_rdy = 1'b1;
        @(negedge clk);

        // Reset held two cycles with a valid mask offered: nothing captured.
        step(1'b1, 1'b0, 1'b1, 16'hFFFF, 1'b1);
        step(1'b1, 1'b0, 1'b1, 16'hFFFF, 1'b1);
        rst = 1'b0; in_vld = 1'b0;
        #1;
        check("reset_out_vld", 32'(out_vld), 32'd0);
        check("reset_in_rdy", 32'(in_rdy), 32'd1);
        check("reset_out_idx", 32'(out_idx), 32'd0);
        check("reset_out_last", 32'(out_last), 32'd0);
        @(negedge clk);
        obs_q.delete(); obs_last_q.delete();

        // Burst
        step(1'b0, 1'b0, 1'b1, 16'h8421, 1'b1);
        idle_cycles(4, 1'b1);
        check_obs("burst", '{0, 5, 10, 15}, '{0, 0, 0, 1});
        idle_cycles(1, 1'b1);

        // Backpressure
        step(1'b0, 1'b0, 1'b1, 16'h0003, 1'b0);
        idle_cycles(3, 1'b0);
        idle_cycles(2, 1'b1);
        check_obs("bp", '{0, 1}, '{0, 1});

        // Back-to-back with in_vld held
        step(1'b0, 1'b0, 1'b1, 16'h0001, 1'b1);
        step(1'b0, 1'b0, 1'b1, 16'h8000, 1'b1);
        step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
        check_obs("b2b", '{0, 15}, '{1, 1});
        idle_cycles(1, 1'b1);

        // Zero mask dropped, then a real mask
        step(1'b0, 1'b0, 1'b1, 16'h0000, 1'b1);
        idle_cycles(1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 16'h0004, 1'b1);
        idle_cycles(2, 1'b1);
        check_obs("zero", '{2}, '{1});

        // Flush mid-mask, next mask starts fresh
        step(1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b1);
        idle_cycles(3, 1'b1);
        step(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
        idle_cycles(1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 16'h0030, 1'b1);
        idle_cycles(3, 1'b1);
        check_obs("flush", '{0, 1, 2, 4, 5}, '{0, 0, 0, 0, 1});

        // Random traffic against the queue model
        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 3))
                0: rm = 16'h0000;
                1: rm = 16'(1 << $urandom_range(0, 15));
                2: rm = 16'($urandom) & 16'($urandom);
                default: rm = 16'($urandom);
            endcase
            step($urandom_range(0, 99) == 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 1) == 1, rm, $urandom_range(0, 3) != 0);
        end
        obs_q.delete(); obs_last_q.delete();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
